// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBC = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// done/prod are combinational so the caller loads the product on the final step edge.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic                busy;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  mcand;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    mplier;

  // Accumulator value after the current step; on the last step this is the full product.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags, carry chaining for ADC/SBC,
// rotates and an iterative multiply that stalls the issuing stage.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  state_t             state, state_d;
  logic               accept_c;
  logic               mul_start_c;
  logic               load_c;
  logic [WIDTH-1:0]   res_c;
  logic               cry_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_cry_c;
  logic               cin_c;
  logic [WIDTH:0]     add_c;
  logic [WIDTH:0]     sub_c;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept_c = in_valid && in_ready;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_c),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle datapath; bit WIDTH of sub_c is the borrow of a - b - C.
  always_comb begin
    cin_c     = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? carry : 1'b0;
    add_c     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_c};
    sub_c     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_c};
    alu_res_c = '0;
    alu_cry_c = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin alu_res_c = add_c[WIDTH-1:0]; alu_cry_c = add_c[WIDTH]; end
      OP_SUB, OP_SBC: begin alu_res_c = sub_c[WIDTH-1:0]; alu_cry_c = sub_c[WIDTH]; end
      OP_AND: alu_res_c = a & b;
      OP_OR:  alu_res_c = a | b;
      OP_XOR: alu_res_c = a ^ b;
      OP_NOT: alu_res_c = ~a;
      OP_SHL: begin alu_res_c = {a[WIDTH-2:0], 1'b0};     alu_cry_c = a[WIDTH-1]; end
      OP_SHR: begin alu_res_c = {1'b0, a[WIDTH-1:1]};     alu_cry_c = a[0];       end
      OP_ROL: begin alu_res_c = {a[WIDTH-2:0], a[WIDTH-1]}; alu_cry_c = a[WIDTH-1]; end
      OP_ROR: begin alu_res_c = {a[0], a[WIDTH-1:1]};     alu_cry_c = a[0];       end
      default: begin alu_res_c = '0; alu_cry_c = 1'b0; end
    endcase
  end

  // Next-state and result-load control.
  always_comb begin
    state_d     = state;
    load_c      = 1'b0;
    mul_start_c = 1'b0;
    res_c       = alu_res_c;
    cry_c       = alu_cry_c;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (opcode == OP_MUL) begin
            mul_start_c = 1'b1;
            state_d     = ST_BUSY;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          load_c  = 1'b1;
          res_c   = mul_prod[WIDTH-1:0];
          cry_c   = |mul_prod[2*WIDTH-1:WIDTH];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // A newly loaded result takes priority over consumption of the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      out       <= res_c;
      carry     <= cry_c;
      zero      <= (res_c == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized scoreboard bench for alu_seq (WIDTH 8, plus a WIDTH 16 instance).
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [7:0] out;
    logic       carry;
    logic       zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, carry, zero;
  logic [3:0]  opcode;
  logic [7:0]  op_a, op_b, res;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, carry16, zero16;
  logic [3:0]  opcode16;
  logic [15:0] a16, b16, res16;

  exp_t q[$];
  exp_t nxt;
  logic model_c;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(op_a), .b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .out(res), .carry(carry), .zero(zero)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .opcode(opcode16), .a(a16), .b(b16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out(res16), .carry(carry16), .zero(zero16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] x,
                                 input logic [7:0] y, input logic c);
    exp_t e;
    int ix, iy, ic, r;
    logic cy;
    ix = int'(x); iy = int'(y); ic = c ? 1 : 0; r = 0; cy = 1'b0;
    case (op)
      4'h0: begin r = ix + iy;      cy = (r > 255);       end
      4'h8: begin r = ix + iy + ic; cy = (r > 255);       end
      4'h1: begin r = ix - iy;      cy = (ix < iy);       end
      4'h9: begin r = ix - iy - ic; cy = (ix < iy + ic);  end
      4'h2: r = ix & iy;
      4'h3: r = ix | iy;
      4'h4: r = ix ^ iy;
      4'h5: r = 255 - ix;
      4'h6: begin r = ix * 2;                         cy = (ix >= 128); end
      4'h7: begin r = ix / 2;                         cy = (ix % 2 == 1); end
      4'hA: begin r = ix * 2 + ix / 128;              cy = (ix >= 128); end
      4'hB: begin r = ix / 2 + (ix % 2) * 128;        cy = (ix % 2 == 1); end
      4'hC: begin r = ix * iy;                        cy = (r > 255); end
      default: r = 0;
    endcase
    e.out   = 8'(r & 255);
    e.carry = cy;
    e.zero  = ((r & 255) == 0);
    return e;
  endfunction

  // One clock: consume/compare a pending result, record an accepted op, advance.
  task automatic cycle();
    exp_t e;
    #2;
    if (out_valid && out_ready) begin
      pops++;
      if (q.size() == 0) begin
        chk("sb_unexpected_result", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("sb_out",   32'(res),   32'(e.out));
        chk("sb_carry", 32'(carry), 32'(e.carry));
        chk("sb_zero",  32'(zero),  32'(e.zero));
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(nxt);
      model_c = nxt.carry;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] eo, input logic ec);
    in_valid  = 1'b1;
    opcode    = op;
    op_a      = x;
    op_b      = y;
    nxt.out   = eo;
    nxt.carry = ec;
    nxt.zero  = (eo == 8'h00);
    cycle();
    in_valid = 1'b0;
    if (op != OP_MUL) chk("result_latency", 32'(out_valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [3:0] rop;
    logic [7:0] ra, rb;
    int p0;

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; opcode16 = '0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
    model_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out",       32'(res),       32'd0);
    chk("rst_carry",     32'(carry),     32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry and borrow chains, shifts, rotates, reserved opcode.
    issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1);
    issue(OP_ADC, 8'h10, 8'h20, 8'h31, 1'b0);
    issue(OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b1);
    issue(OP_SBC, 8'h05, 8'h01, 8'h03, 1'b0);
    issue(OP_ROL, 8'h81, 8'h55, 8'h03, 1'b1);
    issue(OP_ROR, 8'h01, 8'hAA, 8'h80, 1'b1);
    issue(OP_SHL, 8'h81, 8'h33, 8'h02, 1'b1);
    issue(4'hE,   8'h12, 8'h34, 8'h00, 1'b0);
    cycle();

    // Multiply: stall for WIDTH cycles, result exactly WIDTH edges after accept.
    issue(OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_in_ready",  32'(in_ready),  32'd0);
      chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
      cycle();
    end
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    issue(OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0);
    repeat (8) cycle();
    chk("mul2_done_valid", 32'(out_valid), 32'd1);
    cycle();

    // Backpressure, then simultaneous consume and accept.
    out_ready = 1'b0;
    issue(OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0);
    in_valid = 1'b1; opcode = OP_XOR; op_a = 8'hF0; op_b = 8'hFF;
    nxt.out = 8'h0F; nxt.carry = 1'b0; nxt.zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out",       32'(res),       32'h03);
      chk("bp_carry",     32'(carry),     32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("handoff_no_bubble", 32'(out_valid), 32'd1);
    cycle();

    // Sixteen back-to-back non-multiply ops.
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(0, 14));
      if (rop == OP_MUL) rop = 4'hD;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      e  = model(rop, ra, rb, model_c);
      issue(rop, ra, rb, e.out, e.carry);
    end
    cycle();
    chk("b2b_result_count", 32'(pops - p0), 32'd16);

    // Reset in the middle of a multiply discards it.
    issue(OP_MUL, 8'h03, 8'h05, 8'h0F, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out",       32'(res),       32'd0);
    chk("midrst_carry",     32'(carry),     32'd0);
    chk("midrst_zero",      32'(zero),      32'd0);
    q.delete();
    model_c = 1'b0;
    #3 rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    chk("sb_leftover", 32'(q.size()), 32'd0);

    // WIDTH 16 carry-out.
    in_valid16 = 1'b1; opcode16 = OP_ADD; a16 = 16'hFFFF; b16 = 16'h0001;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    chk("w16_out_valid", 32'(out_valid16), 32'd1);
    chk("w16_out",       32'(res16),       32'd0);
    chk("w16_carry",     32'(carry16),     32'd1);
    chk("w16_zero",      32'(zero16),      32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
